pq_stream_sorter: RTL and testbench

PQ_STREAM_SORTER -- requirements
Module: pq_stream_sorter

---
 rtl/pq_stream_sorter_if.sv | 34 +++
 rtl/pq_stream_sorter.sv | 122 ++++++++++++
 tb/tb_pq_stream_sorter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pq_stream_sorter_if.sv
// Stream-in, stream-out and attached priority-queue signals of the batch sorter.
// The slave modport is the sorter's view; the master modport is the environment's view.
interface pq_stream_sorter_if #(
    parameter int KEY_W = 16,
    parameter int VAL_W = 16
);
    localparam int KV_W = KEY_W + VAL_W;

    logic            in_valid;
    logic            in_ready;
    logic [KV_W-1:0] in_kv;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [KV_W-1:0] out_kv;
    logic            out_last;
    logic            pq_enq;
    logic            pq_deq;
    logic [KV_W-1:0] pq_kvi;
    logic [KV_W-1:0] pq_kvo;
    logic            pq_full;
    logic            pq_empty;
    logic            pq_busy;

    modport slave (
        input  in_valid, in_kv, in_last, out_ready, pq_kvo, pq_full, pq_empty, pq_busy,
        output in_ready, out_valid, out_kv, out_last, pq_enq, pq_deq, pq_kvi
    );

    modport master (
        output in_valid, in_kv, in_last, out_ready, pq_kvo, pq_full, pq_empty, pq_busy,
        input  in_ready, out_valid, out_kv, out_last, pq_enq, pq_deq, pq_kvi
    );
endinterface

// File: rtl/pq_stream_sorter.sv
// Batch sorter: loads a batch of key/value beats into an external min-priority queue,
// then drains the queue head by head to produce the batch in ascending key order.
module pq_stream_sorter #(
    parameter  int KEY_W = 16,
    parameter  int VAL_W = 16,
    parameter  int MAX_N = 15,
    localparam int KV_W  = KEY_W + VAL_W,
    localparam int CNT_W = $clog2(MAX_N + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    pq_stream_sorter_if.slave    bus,
    output logic [CNT_W-1:0]     count,
    output logic                 err
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_N);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t           state, stateN;
    logic [CNT_W-1:0] countN;
    logic             gap, gapN;
    logic             enq, enqN, deq, deqN;
    logic [KV_W-1:0]  kvi, kviN;
    logic             oValid, oValidN, oLast, oLastN;
    logic [KV_W-1:0]  oKv, oKvN;
    logic             errN;
    logic             inReady;
    logic             pqOk, outFree;

    // Busy from the queue lags an operation by one cycle; gap masks that window.
    assign pqOk    = !bus.pq_busy && !gap;
    assign outFree = !oValid || bus.out_ready;

    always_comb begin
        stateN  = state;
        countN  = count;
        enqN    = 1'b0;
        deqN    = 1'b0;
        kviN    = kvi;
        oValidN = oValid;
        oKvN    = oKv;
        oLastN  = oLast;
        errN    = err;
        inReady = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) stateN = LOAD;
            end
            LOAD: begin
                inReady = pqOk && !bus.pq_full && (count < MAX_C);
                if (bus.in_valid && inReady) begin
                    enqN   = 1'b1;
                    kviN   = bus.in_kv;
                    countN = count + 1'b1;
                    if (bus.in_last || (count == MAX_C - 1'b1)) stateN = DRAIN;
                end else if (bus.pq_full && (count < MAX_C)) begin
                    errN   = 1'b1;
                    stateN = DRAIN;
                end
            end
            DRAIN: begin
                if (pqOk && (count != '0) && bus.pq_empty) begin
                    // Queue lost entries we still expect: abandon the batch.
                    errN    = 1'b1;
                    oValidN = 1'b0;
                    oLastN  = 1'b0;
                    countN  = '0;
                    stateN  = IDLE;
                end else if (outFree && pqOk && (count != '0)) begin
                    oKvN    = bus.pq_kvo;
                    oValidN = 1'b1;
                    oLastN  = (count == CNT_W'(1));
                    deqN    = 1'b1;
                    countN  = count - 1'b1;
                end else if (oValid && bus.out_ready) begin
                    oValidN = 1'b0;
                    oLastN  = 1'b0;
                    if (oLast) stateN = IDLE;
                end else if (!oValid && (count == '0)) begin
                    stateN = IDLE;
                end
            end
            default: stateN = IDLE;
        endcase
        gapN = enqN || deqN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= '0;
            gap    <= 1'b0;
            enq    <= 1'b0;
            deq    <= 1'b0;
            kvi    <= '0;
            oValid <= 1'b0;
            oKv    <= '0;
            oLast  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= stateN;
            count  <= countN;
            gap    <= gapN;
            enq    <= enqN;
            deq    <= deqN;
            kvi    <= kviN;
            oValid <= oValidN;
            oKv    <= oKvN;
            oLast  <= oLastN;
            err    <= errN;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = oValid;
    assign bus.out_kv    = oKv;
    assign bus.out_last  = oLast;
    assign bus.pq_enq    = enq;
    assign bus.pq_deq    = deq;
    assign bus.pq_kvi    = kvi;
endmodule

// File: tb/tb_pq_stream_sorter.sv
// Scoreboard bench for pq_stream_sorter with a behavioural min-priority-queue model
// whose busy status can be stretched randomly after every operation.
module tb_pq_stream_sorter;
    localparam int KEY_W = 16;
    localparam int VAL_W = 16;
    localparam int MAX_N = 15;
    localparam int KV_W  = KEY_W + VAL_W;
    localparam int CNT_W = $clog2(MAX_N + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pq_stream_sorter_if #(.KEY_W(KEY_W), .VAL_W(VAL_W)) bus ();
    logic [CNT_W-1:0] count;
    logic             err;

    pq_stream_sorter #(.KEY_W(KEY_W), .VAL_W(VAL_W), .MAX_N(MAX_N)) dut (
        .clk  (clk),
        .rst  (rst_n),
        .bus  (bus.slave),
        .count(count),
        .err  (err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [KV_W-1:0] kvOf(input logic [KEY_W-1:0] k);
        return {k, k ^ 16'hBEEF};
    endfunction

    // ---------------- priority queue model ----------------
    logic [KV_W-1:0] pqMem[$];
    int              pqSize;
    logic [KV_W-1:0] pqHead;
    int              busyCnt;
    bit              lastOp;
    bit              stretchEn  = 0;
    bit              forceEmpty = 0;

    assign bus.pq_full  = (pqSize >= MAX_N);
    assign bus.pq_empty = forceEmpty || (pqSize == 0);
    assign bus.pq_kvo   = pqHead;
    assign bus.pq_busy  = (busyCnt != 0);

    function automatic int findPos(input logic [KV_W-1:0] q[$], input logic [KV_W-1:0] kv);
        for (int i = 0; i < q.size(); i++)
            if (q[i][KV_W-1:VAL_W] > kv[KV_W-1:VAL_W]) return i;
        return q.size();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pqMem.delete();
            pqSize  <= 0;
            pqHead  <= '0;
            busyCnt <= 0;
            lastOp  <= 1'b0;
        end else begin
            if (bus.pq_enq || bus.pq_deq) begin
                chk(!(bus.pq_enq && bus.pq_deq) && (busyCnt == 0) && !lastOp, "pq_op_protocol",
                    {bus.pq_enq, bus.pq_deq, (busyCnt != 0), lastOp}, {bus.pq_enq, bus.pq_deq, 2'b00});
                if (bus.pq_enq) pqMem.insert(findPos(pqMem, bus.pq_kvi), bus.pq_kvi);
                if (bus.pq_deq && pqMem.size() > 0) void'(pqMem.pop_front());
                busyCnt <= stretchEn ? int'($urandom_range(0, 3)) : 0;
            end else if (busyCnt != 0) begin
                busyCnt <= busyCnt - 1;
            end
            lastOp <= bus.pq_enq || bus.pq_deq;
            pqSize <= pqMem.size();
            pqHead <= (pqMem.size() > 0) ? pqMem[0] : '0;
        end
    end

    // ---------------- output ready driver ----------------
    bit randReady  = 0;
    bit readyLevel = 1;
    bit readySig;
    assign bus.out_ready = readySig;
    always @(posedge clk) begin
        #2;
        readySig <= randReady ? 1'($urandom_range(0, 1)) : readyLevel;
    end

    // ---------------- scoreboard monitor ----------------
    logic [KV_W:0] expQ[$];
    bit            prevStall;
    logic [KV_W:0] prevOut;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevStall <= 1'b0;
        end else begin
            if (prevStall)
                chk(bus.out_valid && ({bus.out_last, bus.out_kv} == prevOut), "stall_stable",
                    {bus.out_valid, bus.out_last, bus.out_kv}, {1'b1, prevOut});
            if (bus.out_valid && bus.out_ready) begin
                chk(expQ.size() != 0, "unexpected_beat", {bus.out_last, bus.out_kv}, 0);
                if (expQ.size() != 0) begin
                    chk({bus.out_last, bus.out_kv} == expQ[0], "out_beat",
                        {bus.out_last, bus.out_kv}, expQ[0]);
                    void'(expQ.pop_front());
                end
            end
            prevStall <= bus.out_valid && !bus.out_ready;
            prevOut   <= {bus.out_last, bus.out_kv};
        end
    end

    // ---------------- stimulus ----------------
    task automatic sendBeat(input logic [KEY_W-1:0] k, input bit last);
        bus.in_valid = 1'b1;
        bus.in_kv    = kvOf(k);
        bus.in_last  = last;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            if (n >= 400) begin
                chk(1'b0, "in_accept_timeout", k, 1);
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic sendBatch(input logic [KEY_W-1:0] ks[$], input bit lastOnFinal);
        for (int i = 0; i < ks.size(); i++)
            sendBeat(ks[i], lastOnFinal && (i == ks.size() - 1));
    endtask

    task automatic expBatch(input logic [KEY_W-1:0] sorted[$]);
        for (int i = 0; i < sorted.size(); i++)
            expQ.push_back({(i == sorted.size() - 1), kvOf(sorted[i])});
    endtask

    task automatic waitDrain(input string tag);
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !bus.out_valid && count == '0) break;
            if (n >= 3000) begin
                chk(1'b0, {tag, "_drain_timeout"}, expQ.size(), 0);
                expQ.delete();
                break;
            end
        end
        repeat (2) @(negedge clk);
        chk(count == '0, {tag, "_count_zero"}, count, 0);
        chk(!bus.in_ready && !bus.out_valid, {tag, "_idle_outputs"},
            {bus.in_ready, bus.out_valid}, 0);
    endtask

    task automatic checkReset(input string tag);
        chk(bus.in_ready == 1'b0,  {tag, "_in_ready"},  bus.in_ready, 0);
        chk(bus.out_valid == 1'b0, {tag, "_out_valid"}, bus.out_valid, 0);
        chk(bus.out_last == 1'b0,  {tag, "_out_last"},  bus.out_last, 0);
        chk(bus.out_kv == '0,      {tag, "_out_kv"},    bus.out_kv, 0);
        chk(bus.pq_enq == 1'b0,    {tag, "_pq_enq"},    bus.pq_enq, 0);
        chk(bus.pq_deq == 1'b0,    {tag, "_pq_deq"},    bus.pq_deq, 0);
        chk(bus.pq_kvi == '0,      {tag, "_pq_kvi"},    bus.pq_kvi, 0);
        chk(count == '0,           {tag, "_count"},     count, 0);
        chk(err == 1'b0,           {tag, "_err"},       err, 0);
    endtask

    initial begin
        logic [KEY_W-1:0] ks[$];
        logic [KEY_W-1:0] ex[$];
        bus.in_valid = 1'b0;
        bus.in_kv    = '0;
        bus.in_last  = 1'b0;

        // Reset without any clock edge.
        #1 rst_n = 1'b0;
        #2 checkReset("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic batch.
        ex = '{16'd1, 16'd3, 16'd7, 16'd9};
        expBatch(ex);
        ks = '{16'd7, 16'd3, 16'd9, 16'd1};
        sendBatch(ks, 1'b1);
        waitDrain("b4");
        chk(err == 1'b0, "b4_err", err, 0);

        // 20 beats: first 15 auto-close a batch, last 5 form the next one.
        ex = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd8, 16'd9, 16'd10,
               16'd11, 16'd12, 16'd15, 16'd16, 16'd17, 16'd18, 16'd19};
        expBatch(ex);
        ex = '{16'd6, 16'd7, 16'd13, 16'd14, 16'd20};
        expBatch(ex);
        ks = '{16'd1, 16'd8, 16'd15, 16'd2, 16'd9, 16'd16, 16'd3, 16'd10, 16'd17, 16'd4,
               16'd11, 16'd18, 16'd5, 16'd12, 16'd19, 16'd6, 16'd13, 16'd20, 16'd7, 16'd14};
        sendBatch(ks, 1'b1);
        waitDrain("b20");
        chk(err == 1'b0, "b20_err", err, 0);

        // Single-beat batch.
        ex = '{16'd5};
        expBatch(ex);
        ks = '{16'd5};
        sendBatch(ks, 1'b1);
        waitDrain("b1");

        // Random back-pressure and stretched queue busy.
        stretchEn = 1;
        randReady = 1;
        ex = '{16'd1, 16'd7, 16'd12, 16'd25, 16'd33, 16'd40};
        expBatch(ex);
        ks = '{16'd12, 16'd40, 16'd7, 16'd33, 16'd1, 16'd25};
        sendBatch(ks, 1'b1);
        waitDrain("brand");
        stretchEn = 0;
        randReady = 0;
        chk(err == 1'b0, "brand_err", err, 0);

        // Queue claims empty while two entries are outstanding.
        ks = '{16'd8, 16'd6};
        sendBatch(ks, 1'b1);
        forceEmpty = 1;
        repeat (6) @(negedge clk);
        chk(err == 1'b1, "empty_err_set", err, 1);
        chk(count == '0, "empty_err_count", count, 0);
        chk(bus.out_valid == 1'b0, "empty_err_no_out", bus.out_valid, 0);
        chk(bus.in_ready == 1'b0, "empty_err_idle", bus.in_ready, 0);
        repeat (3) @(negedge clk);
        chk(err == 1'b1, "empty_err_sticky", err, 1);
        forceEmpty = 0;
        #1 rst_n = 1'b0;
        #1 checkReset("rst_after_err");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while a beat is stalled in the output register.
        readyLevel = 0;
        ks = '{16'd30, 16'd10, 16'd20};
        sendBatch(ks, 1'b1);
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            if (n >= 200) begin
                chk(1'b0, "drain_valid_timeout", bus.out_valid, 1);
                break;
            end
        end
        chk(bus.out_valid && bus.out_kv == kvOf(16'd10), "stalled_head",
            {bus.out_valid, bus.out_kv}, {1'b1, kvOf(16'd10)});
        #1 rst_n = 1'b0;
        #1 checkReset("rst_mid_drain");
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        readyLevel = 1;
        @(posedge clk); #3;
        ex = '{16'd2, 16'd4};
        expBatch(ex);
        ks = '{16'd4, 16'd2};
        sendBatch(ks, 1'b1);
        waitDrain("post_rst");
        chk(err == 1'b0, "post_rst_err", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
